ew_threat_logger: RTL and testbench

Downstream event recorder for `ew_sim_top`. It watches the top's `fsm_state`, `comm_channel` and `system_fault` outputs every clock. Each FSM transition, and each rising edge of the fault flag, becomes a timestamped log entry in an internal FIFO. A host or readout stage drains the FIFO through a valid/ready port, and the block keeps threat and overflow statistics alongside the log.

---
 rtl/ew_sim_pkg.sv | 38 +++
 rtl/ew_log_fifo.sv | 59 +++++
 rtl/ew_threat_logger.sv | 96 +++++++++
 tb/tb_ew_threat_logger.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ew_sim_pkg.sv
// Shared types and constants for the EW simulation slice.
package ew_sim_pkg;

  // State codes driven by ew_sim_top; code 7 is unused and treated as invalid.
  typedef enum logic [2:0] {
    StIdle           = 3'd0,
    StJammed         = 3'd1,
    StSpoofDetected  = 3'd2,
    StAuthenticating = 3'd3,
    StRecovery       = 3'd4,
    StLogging        = 3'd5,
    StThreatKnown    = 3'd6
  } ew_state_e;

  // Log record. The timestamp is parameterised per instance, so it sits in front of this
  // fixed-width part: rd_data = {ts, log_entry_t}. Raw codes are kept so 7 can be logged.
  typedef struct packed {
    logic [2:0] prev_state;
    logic [2:0] new_state;
    logic [1:0] channel;
    logic       fault;
  } log_entry_t;

  localparam int unsigned EntryTailW = $bits(log_entry_t);

  localparam ew_state_e THREAT_STATES [3] = '{StJammed, StSpoofDetected, StThreatKnown};

  // True when a raw state code is one of the threat states.
  function automatic logic is_threat(logic [2:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (code == THREAT_STATES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ew_log_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop happens on the same edge.
module ew_log_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,   // synchronous, active-low
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok;

  // Accept/pop qualification and occupancy next-state.
  always_comb begin
    full_o    = (count_q == (AW + 1)'(DEPTH));
    empty_o   = (count_q == '0);
    push_ok_o = push_i && (!full_o || pop_i);
    pop_ok    = pop_i && !empty_o;
    count_d   = count_q;
    unique case ({push_ok_o, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Head is forced to zero while empty so storage never needs clearing.
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)    rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage write; contents are left as-is on reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ew_threat_logger.sv
// Timestamped recorder of FSM transitions and fault rises from ew_sim_top.
module ew_threat_logger
  import ew_sim_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,        // synchronous, active-low
  input  logic [2:0]               fsm_state,
  input  logic [1:0]               comm_channel,
  input  logic                     system_fault,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W+8:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               overflow_cnt,
  output logic [7:0]               threat_cnt,
  output logic                     threat_irq
);

  localparam int unsigned EntryW = TS_W + EntryTailW;

  logic [TS_W-1:0]   ts_q;
  logic              primed_q;
  logic [2:0]        last_state_q;
  logic              last_fault_q;
  logic [7:0]        overflow_cnt_q, threat_cnt_q;
  logic              threat_irq_q;

  logic              event_hit, pop, push_ok, fifo_full, fifo_empty, dropped;
  log_entry_t        tail;
  logic [EntryW-1:0] entry;

  // Event detection and entry assembly; a coincident state change and fault rise is one event.
  always_comb begin
    event_hit = primed_q &&
                ((fsm_state != last_state_q) || (system_fault && !last_fault_q));
    tail.prev_state = last_state_q;
    tail.new_state  = fsm_state;
    tail.channel    = comm_channel;
    tail.fault      = system_fault;
    entry           = {ts_q, tail};
    pop             = rd_valid && rd_ready;
    dropped         = event_hit && !push_ok;
  end

  ew_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .push_i    (event_hit),
    .data_i    (entry),
    .pop_i     (pop),
    .data_o    (rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .push_ok_o (push_ok),
    .count_o   (count)
  );

  // Timestamp, history tracking and saturating statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ts_q           <= '0;
      primed_q       <= 1'b0;
      last_state_q   <= '0;
      last_fault_q   <= 1'b0;
      overflow_cnt_q <= '0;
      threat_cnt_q   <= '0;
      threat_irq_q   <= 1'b0;
    end else begin
      ts_q         <= ts_q + 1'b1;
      primed_q     <= 1'b1;
      // Loaded every cycle: this is both the priming load and the per-cycle history update.
      last_state_q <= fsm_state;
      last_fault_q <= system_fault;
      if (dropped && (overflow_cnt_q != 8'hFF)) overflow_cnt_q <= overflow_cnt_q + 1'b1;
      threat_irq_q <= push_ok && is_threat(fsm_state);
      if (push_ok && is_threat(fsm_state) && (threat_cnt_q != 8'hFF)) begin
        threat_cnt_q <= threat_cnt_q + 1'b1;
      end
    end
  end

  // Output mapping.
  always_comb begin
    rd_valid     = !fifo_empty;
    overflow_cnt = overflow_cnt_q;
    threat_cnt   = threat_cnt_q;
    threat_irq   = threat_irq_q;
  end

endmodule

// File: tb/tb_ew_threat_logger.sv
// Directed bench for ew_threat_logger (DEPTH=16, TS_W=4 so timestamp wrap is reachable).
module tb_ew_threat_logger;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fsm_state;
  logic [1:0]  comm_channel;
  logic        system_fault;
  logic        rd_ready;
  logic        rd_valid;
  logic [12:0] rd_data;
  logic [4:0]  count;
  logic [7:0]  overflow_cnt, threat_cnt;
  logic        threat_irq;

  int n_checks = 0;
  int n_pass   = 0;

  ew_threat_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fsm_state    (fsm_state),
    .comm_channel (comm_channel),
    .system_fault (system_fault),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .count        (count),
    .overflow_cnt (overflow_cnt),
    .threat_cnt   (threat_cnt),
    .threat_irq   (threat_irq)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [12:0] ent(int ts, int p, int n, int c, int f);
    return {4'(ts), 3'(p), 3'(n), 2'(c), 1'(f)};
  endfunction

  // Expected record i of the overflow burst: states alternate 3/5 from 7, channel i%4, fault 1.
  function automatic logic [12:0] burst_ent(int i);
    int p, n;
    n = (i % 2 == 0) ? 3 : 5;
    p = (i == 0) ? 7 : (((i - 1) % 2 == 0) ? 3 : 5);
    return ent((13 + i) % 16, p, n, i % 4, 1);
  endfunction

  initial begin
    reset = 1'b0; fsm_state = 3'd0; comm_channel = 2'd0; system_fault = 1'b0; rd_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow_cnt), 0);
    chk("rst_thr", 32'(threat_cnt), 0);
    chk("rst_irq", 32'(threat_irq), 0);

    // Prime at E0, hold through E2, transition 0->1 at E3 (ts=3).
    reset = 1'b1;
    step(); step(); step();
    chk("prime_count", 32'(count), 0);
    chk("prime_valid", 32'(rd_valid), 0);
    fsm_state = 3'd1; comm_channel = 2'd2;
    step();
    chk("ev1_valid", 32'(rd_valid), 1);
    chk("ev1_data", 32'(rd_data), 32'(ent(3, 0, 1, 2, 0)));
    chk("ev1_count", 32'(count), 1);
    chk("ev1_irq", 32'(threat_irq), 1);
    chk("ev1_thr", 32'(threat_cnt), 1);
    step();
    chk("ev1_irq_off", 32'(threat_irq), 0);
    chk("ev1_hold_count", 32'(count), 1);
    rd_ready = 1'b1;
    step();                                   // E5 pops it
    chk("ev1_pop_count", 32'(count), 0);
    chk("ev1_pop_data", 32'(rd_data), 0);

    // Fault rise and coincident events, consumer always ready.
    fsm_state = 3'd4;
    step();                                   // E6
    chk("to4_data", 32'(rd_data), 32'(ent(6, 1, 4, 2, 0)));
    system_fault = 1'b1;
    step();                                   // E7: pop previous, push fault-only entry
    chk("fault_count", 32'(count), 1);
    chk("fault_data", 32'(rd_data), 32'(ent(7, 4, 4, 2, 1)));
    system_fault = 1'b0;
    step();                                   // E8: fall is not an event
    chk("fall_count", 32'(count), 0);
    fsm_state = 3'd2; system_fault = 1'b1;
    step();                                   // E9: one entry for both causes
    chk("coin_count", 32'(count), 1);
    chk("coin_data", 32'(rd_data), 32'(ent(9, 4, 2, 2, 1)));
    chk("coin_thr", 32'(threat_cnt), 2);
    chk("coin_irq", 32'(threat_irq), 1);
    step();                                   // E10
    chk("coin_single", 32'(count), 0);
    fsm_state = 3'd7;
    step();                                   // E11: invalid code is logged, not a threat
    chk("inv_data", 32'(rd_data), 32'(ent(11, 2, 7, 2, 1)));
    chk("inv_irq", 32'(threat_irq), 0);
    chk("inv_thr", 32'(threat_cnt), 2);
    step();                                   // E12
    chk("inv_pop", 32'(count), 0);

    // Overflow: 20 transitions at E13..E32 with no consumer.
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fsm_state = (i % 2 == 0) ? 3'd3 : 3'd5;
      comm_channel = 2'(i % 4);
      step();
    end
    chk("ovf_count", 32'(count), 16);
    chk("ovf_cnt", 32'(overflow_cnt), 4);
    chk("ovf_thr", 32'(threat_cnt), 2);
    chk("ovf_head", 32'(rd_data), 32'(burst_ent(0)));

    // Push and pop on the same edge while full (E33).
    rd_ready = 1'b1; fsm_state = 3'd0; comm_channel = 2'd0;
    step();
    chk("fullpp_count", 32'(count), 16);
    chk("fullpp_ovf", 32'(overflow_cnt), 4);
    for (int j = 1; j < 16; j++) begin
      chk($sformatf("drain_%0d", j), 32'(rd_data), 32'(burst_ent(j)));
      step();
    end
    chk("drain_last", 32'(rd_data), 32'(ent(1, 5, 0, 0, 1)));
    step();                                   // E49
    chk("drain_empty_valid", 32'(rd_valid), 0);
    chk("drain_empty_count", 32'(count), 0);

    // Empty boundary: ready while empty, then push with ready while empty.
    step();                                   // E50
    chk("empty_ready_count", 32'(count), 0);
    fsm_state = 3'd6;
    step();                                   // E51
    chk("empty_push_valid", 32'(rd_valid), 1);
    chk("empty_push_count", 32'(count), 1);
    chk("empty_push_data", 32'(rd_data), 32'(ent(3, 0, 6, 0, 1)));
    chk("empty_push_thr", 32'(threat_cnt), 3);

    // Queue 5 entries, then reset with an event in flight.
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fsm_state = (i % 2 == 0) ? 3'd3 : 3'd5;
      step();
    end
    chk("pre_rst_count", 32'(count), 5);
    reset = 1'b0; fsm_state = 3'd1;
    step();
    chk("mid_rst_valid", 32'(rd_valid), 0);
    chk("mid_rst_data", 32'(rd_data), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_ovf", 32'(overflow_cnt), 0);
    chk("mid_rst_thr", 32'(threat_cnt), 0);
    chk("mid_rst_irq", 32'(threat_irq), 0);

    // Timestamp wrap: prime at E0, event at E17 logs 17 mod 16 = 1.
    system_fault = 1'b0;
    reset = 1'b1;
    step();
    for (int i = 0; i < 16; i++) step();
    chk("wrap_idle_count", 32'(count), 0);
    fsm_state = 3'd2; comm_channel = 2'd3;
    step();
    chk("wrap_count", 32'(count), 1);
    chk("wrap_data", 32'(rd_data), 32'(ent(1, 1, 2, 3, 0)));
    chk("wrap_thr", 32'(threat_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
